// File: rtl/booth_code_gen.sv
// Radix-4 Booth encoder/sequencer: latches a signed operand and emits one one-hot NUM_CODE per digit, MSB digit first.
// Latency: first code valid the cycle after operand accept; N = INPUT_WIDTH/2 beats per operand, zero bubble back-to-back.
// Backpressure: out_ready=0 holds the current code stable; a new operand is accepted only when idle or on the last beat.
// Ports: clk/reset_n (async active-low), in_valid/in_ready/in_operand (operand handshake),
//        out_valid/out_ready/NUM_CODE/out_digit_idx/out_last (code stream), busy (operand in flight).
module booth_code_gen #(
    parameter int INPUT_WIDTH    = 8,
    parameter int NUM_CODE_WIDTH = 5,
    parameter int IDX_WIDTH      = ((INPUT_WIDTH / 2) > 1) ? $clog2(INPUT_WIDTH / 2) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INPUT_WIDTH-1:0]    in_operand,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_CODE_WIDTH-1:0] NUM_CODE,
    output logic [IDX_WIDTH-1:0]      out_digit_idx,
    output logic                      out_last,
    output logic                      busy
);

    localparam int N = INPUT_WIDTH / 2;
    localparam logic [IDX_WIDTH-1:0] TOP_IDX = IDX_WIDTH'(N - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    generate
        if ((INPUT_WIDTH % 2) != 0 || INPUT_WIDTH < 2) begin : g_bad_width
            $error("booth_code_gen: INPUT_WIDTH must be a positive even number");
        end
        if (NUM_CODE_WIDTH != 5) begin : g_bad_code
            $error("booth_code_gen: NUM_CODE_WIDTH must be 5");
        end
    endgenerate

    logic [0:0]             state;
    logic [INPUT_WIDTH-1:0] operand;
    logic [IDX_WIDTH-1:0]   idx;

    logic                   accept;
    logic                   beat;
    logic [INPUT_WIDTH:0]   ext;      // operand with the implicit b[-1]=0 appended at the bottom
    logic [2:0]             triplet;  // {b[2i+1], b[2i], b[2i-1]} for the current digit
    logic [4:0]             code;

    assign busy          = (state == EMIT);
    assign out_valid     = busy;
    assign out_last      = busy && (idx == '0);
    assign out_digit_idx = idx;
    assign beat          = out_valid && out_ready;
    // reset_n gates ready so no operand can be offered-and-accepted while held in reset.
    assign in_ready      = reset_n && ((state == IDLE) || (beat && out_last));
    assign accept        = in_valid && in_ready;

    assign ext = {operand, 1'b0};

    always_comb begin
        triplet = 3'b000;
        for (int i = 0; i < N; i++) begin
            if (idx == IDX_WIDTH'(i)) begin
                triplet = ext[2*i +: 3];
            end
        end
    end

    always_comb begin
        code = 5'b10000;
        case (triplet)
            3'b001, 3'b010: code = 5'b00010;
            3'b011:         code = 5'b01000;
            3'b100:         code = 5'b00100;
            3'b101, 3'b110: code = 5'b00001;
            default:        code = 5'b10000;
        endcase
    end

    // Idle presents the zero code so the PE chain sees a bypass when nothing is valid.
    assign NUM_CODE = out_valid ? code : 5'b10000;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            operand <= '0;
            idx     <= '0;
        end else if (accept) begin
            // Covers both the idle accept and the same-cycle reload on the last beat.
            operand <= in_operand;
            idx     <= TOP_IDX;
            state   <= EMIT;
        end else if (beat) begin
            if (idx == '0) begin
                state <= IDLE;
            end else begin
                idx <= idx - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_booth_code_gen.sv
// Self-checking bench for booth_code_gen: randomized handshakes checked against a digit-arithmetic reference model.
// Latency: expectations are queued on accept and consumed on each observed output beat.
// Backpressure: out_ready patterns (always, 1-0-0 toggle, random) exercise stalls and back-to-back reloads.
module tb_booth_code_gen;

    localparam int W = 8;
    localparam int N = W / 2;

    typedef struct {
        logic [4:0] code;
        int         idx;
        bit         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_operand = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [4:0]   num_code;
    logic [1:0]   out_digit_idx;
    logic         out_last;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] pend[$];
    beat_t        expq[$];
    int           accq[$];
    logic [4:0]   seen[$];
    int           acc = 0;

    booth_code_gen #(
        .INPUT_WIDTH   (W),
        .NUM_CODE_WIDTH(5)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_operand   (in_operand),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .NUM_CODE     (num_code),
        .out_digit_idx(out_digit_idx),
        .out_last     (out_last),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Booth digit value from the defining formula, b[-1] = 0.
    function automatic int digit_of(input logic [W-1:0] op, input int i);
        int hi, mid, lo;
        hi  = int'(op[2*i+1]);
        mid = int'(op[2*i]);
        lo  = (i == 0) ? 0 : int'(op[2*i-1]);
        return -2 * hi + mid + lo;
    endfunction

    function automatic logic [4:0] code_of(input int d);
        case (d)
            1:       return 5'b00010;
            2:       return 5'b01000;
            -2:      return 5'b00100;
            -1:      return 5'b00001;
            default: return 5'b10000;
        endcase
    endfunction

    function automatic int value_of(input logic [4:0] c);
        case (c)
            5'b00010: return 1;
            5'b01000: return 2;
            5'b00100: return -2;
            5'b00001: return -1;
            default:  return 0;
        endcase
    endfunction

    task automatic push_operand(input logic [W-1:0] op);
        beat_t b;
        for (int i = N - 1; i >= 0; i--) begin
            b.code = code_of(digit_of(op, i));
            b.idx  = i;
            b.last = (i == 0);
            expq.push_back(b);
        end
        accq.push_back(int'($signed(op)));
    endtask

    // rdy_mode: 0 always ready, 1 ready every third cycle, 2 random.
    task automatic run_ops(input int rdy_mode, input int vld_pct, input int abort_at, input int budget);
        int    cyc = 0;
        int    beats = 0;
        bit    aborted = 0;
        bit    exp_rdy;
        beat_t b;
        while ((pend.size() > 0 || expq.size() > 0) && cyc < budget) begin
            @(negedge clk);
            if (abort_at > 0 && !aborted && beats == abort_at) begin
                aborted = 1;
                reset_n = 1'b0;
                #1;
                check("abort_out_valid", out_valid, 0);
                check("abort_in_ready", in_ready, 0);
                check("abort_busy", busy, 0);
                check("abort_code", num_code, 5'b10000);
                expq.delete();
                accq.delete();
                seen.delete();
                acc = 0;
                @(negedge clk);
                reset_n = 1'b1;
            end
            in_valid   = (pend.size() > 0) && ($urandom_range(99) < vld_pct);
            in_operand = in_valid ? pend[0] : W'($urandom);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc % 3) == 0);
                default: out_ready = $urandom_range(1);
            endcase
            #1;
            exp_rdy = (expq.size() == 0) || (expq.size() == 1 && out_ready);
            check("in_ready", in_ready, exp_rdy);
            check("out_valid", out_valid, expq.size() > 0);
            check("busy", busy, expq.size() > 0);
            if (out_valid && expq.size() > 0) begin
                b = expq[0];
                check("code", num_code, b.code);
                check("idx", out_digit_idx, b.idx);
                check("last", out_last, b.last);
                check("onehot", $countones(num_code), 1);
                if (out_ready) begin
                    void'(expq.pop_front());
                    beats++;
                    seen.push_back(num_code);
                    acc = acc * 4 + value_of(num_code);
                    if (b.last && accq.size() > 0) begin
                        check("digit_sum", acc, accq.pop_front());
                        acc = 0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                push_operand(in_operand);
                void'(pend.pop_front());
            end
            cyc++;
        end
        check("work_left_at_end", pend.size() + expq.size(), 0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    logic [4:0] t2_exp[4];
    logic [4:0] t3_exp[8];
    logic [4:0] t6_exp[4];

    initial begin
        t2_exp = '{5'b10000, 5'b10000, 5'b01000, 5'b00001};
        t3_exp = '{5'b00100, 5'b10000, 5'b10000, 5'b10000,
                   5'b10000, 5'b10000, 5'b10000, 5'b00001};
        t6_exp = '{5'b00100, 5'b10000, 5'b10000, 5'b10000};

        // T1: held in reset with random inputs
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid   = $urandom_range(1);
            in_operand = W'($urandom);
            out_ready  = $urandom_range(1);
            #1;
            check("rst_out_valid", out_valid, 0);
            check("rst_code", num_code, 5'b10000);
            check("rst_in_ready", in_ready, 0);
            check("rst_busy", busy, 0);
            check("rst_idx", out_digit_idx, 0);
            check("rst_last", out_last, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);

        // T2: single operand 7, always ready
        seen.delete();
        pend.push_back(8'sd7);
        run_ops(0, 100, 0, 50);
        check("t2_beats", seen.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < seen.size()) check("t2_code", seen[i], t2_exp[i]);

        // T3: 0x80 then 0xFF back-to-back
        seen.delete();
        pend.push_back(8'h80);
        pend.push_back(8'hFF);
        run_ops(0, 100, 0, 50);
        check("t3_beats", seen.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < seen.size()) check("t3_code", seen[i], t3_exp[i]);

        // T4: operand 7 under a 1,0,0 ready pattern
        seen.delete();
        pend.push_back(8'sd7);
        run_ops(1, 100, 0, 60);
        check("t4_beats", seen.size(), 4);

        // T5: every operand, random valid and ready
        for (int v = 0; v < 256; v++) pend.push_back(W'(v));
        run_ops(2, 70, 0, 8000);

        // T6: reset after the second beat of 7, then 0x80 starts fresh
        seen.delete();
        pend.push_back(8'sd7);
        pend.push_back(8'h80);
        run_ops(0, 100, 2, 60);
        check("t6_beats", seen.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < seen.size()) check("t6_code", seen[i], t6_exp[i]);

        // Extra random traffic with random operands
        for (int i = 0; i < 40; i++) pend.push_back(W'($urandom));
        run_ops(2, 60, 0, 2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
